// File: rtl/palette_fader_if.sv
// Palette host-port bundle between the fader (master) and the palette RAM
// arbiter (slave). hold is raised by the arbiter while the CPU owns the port.
interface palette_fader_if;
    logic [5:0]  pal_addr;
    logic [15:0] pal_rddata;
    logic [15:0] pal_wrdata;
    logic        pal_wren;
    logic        hold;

    modport master (
        output pal_addr,
        output pal_wrdata,
        output pal_wren,
        input  pal_rddata,
        input  hold
    );

    modport slave (
        input  pal_addr,
        input  pal_wrdata,
        input  pal_wren,
        output pal_rddata,
        output hold
    );
endinterface

// File: rtl/palette_fader.sv
// Palette fader: walks a (possibly wrapping) range of 12-bit palette entries
// once per TICK_DIV tick pulses, nudging each channel towards the target by at
// most STEP, until a full pass makes no change.
// Optional feature macro: PALETTE_FADER_IRQ_EN (sticky irq on done, cleared by
// irq_clr; when undefined irq is tied low).
//
// state  | meaning
// IDLE   | waiting for start
// WAIT   | counting tick pulses before the next pass
// RD     | palette entry at index is being read
// WR     | updated entry written back if it changed
// DONE   | one-cycle done pulse, then back to IDLE
module palette_fader #(
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   tick,
    input  logic [5:0]             first_idx,
    input  logic [5:0]             last_idx,
    input  logic [11:0]            target,
    palette_fader_if.master        pal,
    output logic                   busy,
    output logic                   done,
    output logic                   irq,
    input  logic                   irq_clr
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_WR, S_DONE} state_t;

    localparam logic [3:0] STEP_V   = 4'(STEP);
    localparam logic [7:0] TICK_TOP = 8'(TICK_DIV - 1);

    state_t      state, state_nxt;
    logic [5:0]  index;
    logic [7:0]  tick_cnt;
    logic        changed;
    logic [11:0] cur;
    logic [5:0]  first_q;
    logic [5:0]  last_q;
    logic [11:0] tgt_q;
    logic [11:0] new_col;
    logic        wr_hit;
    logic        tick_last;

    // Move one 4-bit channel towards its target by at most STEP; never wraps.
    function automatic logic [3:0] chan_next(input logic [3:0] c, input logic [3:0] t);
        logic [3:0] d;
        logic [3:0] r;
        r = c;
        if (c < t) begin
            d = t - c;
            r = c + ((d < STEP_V) ? d : STEP_V);
        end else if (c > t) begin
            d = c - t;
            r = c - ((d < STEP_V) ? d : STEP_V);
        end
        return r;
    endfunction

    assign new_col   = {chan_next(cur[11:8], tgt_q[11:8]),
                        chan_next(cur[7:4],  tgt_q[7:4]),
                        chan_next(cur[3:0],  tgt_q[3:0])};
    assign wr_hit    = (new_col != cur);
    assign tick_last = (tick_cnt == TICK_TOP);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; abort overrides everything, hold freezes RD/WR.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_WAIT;
                S_WAIT: if (tick && tick_last) state_nxt = S_RD;
                S_RD:   if (!pal.hold) state_nxt = S_WR;
                S_WR: begin
                    if (!pal.hold) begin
                        if (index == last_q) state_nxt = (changed || wr_hit) ? S_WAIT : S_DONE;
                        else                 state_nxt = S_RD;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: range/target latch, tick counter, entry index and read capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index    <= '0;
            tick_cnt <= '0;
            changed  <= 1'b0;
            cur      <= '0;
            first_q  <= '0;
            last_q   <= '0;
            tgt_q    <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        first_q  <= first_idx;
                        last_q   <= last_idx;
                        tgt_q    <= target;
                        index    <= first_idx;
                        changed  <= 1'b0;
                        tick_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            index    <= first_q;
                            changed  <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                S_RD: begin
                    if (!pal.hold) cur <= pal.pal_rddata[11:0];
                end
                S_WR: begin
                    if (!pal.hold) begin
                        changed <= changed | wr_hit;
                        if (index != last_q) index <= index + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; everything is forced quiet while reset_n is low.
    always_comb begin
        pal.pal_addr   = '0;
        pal.pal_wrdata = '0;
        pal.pal_wren   = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        if (reset_n) begin
            case (state)
                S_WAIT: busy = 1'b1;
                S_RD: begin
                    busy         = 1'b1;
                    pal.pal_addr = index;
                end
                S_WR: begin
                    busy         = 1'b1;
                    pal.pal_addr = index;
                    if (wr_hit && !pal.hold && !abort) begin
                        pal.pal_wren   = 1'b1;
                        pal.pal_wrdata = {4'h0, new_col};
                    end
                end
                S_DONE:  done = !abort;
                default: ;
            endcase
        end
    end

    logic unused_rd_hi;
    assign unused_rd_hi = ^pal.pal_rddata[15:12];

`ifdef PALETTE_FADER_IRQ_EN
    logic irq_q;

    // Sticky interrupt: a done pulse beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n)     irq_q <= 1'b0;
        else if (done)    irq_q <= 1'b1;
        else if (irq_clr) irq_q <= 1'b0;
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_palette_fader.sv
// Bench for palette_fader: two instances (STEP=1/TICK_DIV=1 and STEP=2/TICK_DIV=3)
// each with its own palette memory, checked against a pass-by-pass colour model.
module tb_palette_fader;

    localparam int STEP_A = 1, TD_A = 1, STEP_B = 2, TD_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, abort, tick, hold, irq_clr;
    logic [1:0]  start;
    logic [5:0]  first_idx, last_idx;
    logic [11:0] target;
    logic        busy_s [2];
    logic        done_s [2];
    logic        irq_s  [2];
    logic        wren_s [2];
    logic [5:0]  addr_s [2];
    logic [15:0] wdata_s[2];

    palette_fader_if bus_a();
    palette_fader_if bus_b();

    logic [11:0] mem [2][64];
    logic        load_req [2];
    logic [11:0] load_buf [64];

    assign bus_a.pal_rddata = {4'h0, mem[0][bus_a.pal_addr]};
    assign bus_b.pal_rddata = {4'h0, mem[1][bus_b.pal_addr]};
    assign bus_a.hold = hold;
    assign bus_b.hold = hold;
    assign wren_s[0]  = bus_a.pal_wren;
    assign wren_s[1]  = bus_b.pal_wren;
    assign addr_s[0]  = bus_a.pal_addr;
    assign addr_s[1]  = bus_b.pal_addr;
    assign wdata_s[0] = bus_a.pal_wrdata;
    assign wdata_s[1] = bus_b.pal_wrdata;

    palette_fader #(.STEP(STEP_A), .TICK_DIV(TD_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort), .tick(tick),
        .first_idx(first_idx), .last_idx(last_idx), .target(target), .pal(bus_a),
        .busy(busy_s[0]), .done(done_s[0]), .irq(irq_s[0]), .irq_clr(irq_clr));

    palette_fader #(.STEP(STEP_B), .TICK_DIV(TD_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort), .tick(tick),
        .first_idx(first_idx), .last_idx(last_idx), .target(target), .pal(bus_b),
        .busy(busy_s[1]), .done(done_s[1]), .irq(irq_s[1]), .irq_clr(irq_clr));

    int checks = 0, errors = 0;
    logic [17:0] wlog0[$], wlog1[$];
    int done_n[2] = '{0, 0};
    int hi_bad = 0, hold_bad = 0;

    // Palette memories, write logs and pulse counters.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (load_req[u]) begin
                for (int i = 0; i < 64; i++) mem[u][i] <= load_buf[i];
            end else if (wren_s[u]) begin
                mem[u][addr_s[u]] <= wdata_s[u][11:0];
            end
            if (wren_s[u]) begin
                if (u == 0) wlog0.push_back({addr_s[u], wdata_s[u][11:0]});
                else        wlog1.push_back({addr_s[u], wdata_s[u][11:0]});
                if (wdata_s[u][15:12] != 4'h0) hi_bad++;
                if (hold) hold_bad++;
            end
            if (done_s[u]) done_n[u]++;
        end
    end

    function automatic int log_n(input int u);
        return (u == 0) ? wlog0.size() : wlog1.size();
    endfunction

    function automatic logic [17:0] log_at(input int u, input int i);
        return (u == 0) ? wlog0[i] : wlog1[i];
    endfunction

    function automatic int step_of(input int u);
        return (u == 0) ? STEP_A : STEP_B;
    endfunction

    function automatic int td_of(input int u);
        return (u == 0) ? TD_A : TD_B;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole passes over the range with plain integer arithmetic.
    logic [11:0] img0[64];
    logic [11:0] exp_img[64];
    logic [17:0] exp_w[$];
    int          exp_p;

    function automatic logic [3:0] ch_next(input int c, input int t, input int s);
        if (c < t) return 4'(c + (((t - c) < s) ? (t - c) : s));
        if (c > t) return 4'(c - (((c - t) < s) ? (c - t) : s));
        return 4'(c);
    endfunction

    task automatic model(input int step, input logic [5:0] f, input logic [5:0] l,
                         input logic [11:0] tgt, input int max_p);
        int n;
        bit chg;
        exp_w.delete();
        exp_img = img0;
        exp_p   = 0;
        n = ((int'(l) - int'(f) + 64) % 64) + 1;
        do begin
            chg = 0;
            for (int k = 0; k < n; k++) begin
                int idx;
                logic [11:0] nv;
                idx = (int'(f) + k) % 64;
                for (int ch = 0; ch < 3; ch++)
                    nv[4*ch +: 4] = ch_next(int'(exp_img[idx][4*ch +: 4]), int'(tgt[4*ch +: 4]), step);
                if (nv != exp_img[idx]) begin
                    exp_w.push_back({6'(idx), nv});
                    exp_img[idx] = nv;
                    chg = 1;
                end
            end
            exp_p++;
        end while (chg && exp_p < max_p);
    endtask

    task automatic load_mem(input int u);
        load_buf = img0;
        load_req[u] = 1'b1;
        @(negedge clk);
        load_req[u] = 1'b0;
    endtask

    task automatic rand_img();
        for (int i = 0; i < 64; i++) img0[i] = 12'($urandom);
    endtask

    task automatic chk_mem(input int u, input string tag);
        int mism = 0;
        for (int i = 0; i < 64; i++) if (mem[u][i] !== exp_img[i]) mism++;
        chk({tag, " palette image"}, 32'(mism), 32'd0);
    endtask

    // One full fade: spacing 0 = tick held high, else one tick every spacing cycles.
    task automatic run_fade(input int u, input logic [5:0] f, input logic [5:0] l,
                            input logic [11:0] tgt, input int spacing, input int hold_at,
                            input bit bogus, input string tag);
        int base, dbase, busy_cnt, tick_cnt, hold_left, n, exp_busy, mism;
        bit seen, held;
        logic [15:0] d0;
        n = ((int'(l) - int'(f) + 64) % 64) + 1;
        model(step_of(u), f, l, tgt, 1000);
        load_mem(u);
        base = log_n(u); dbase = done_n[u];
        busy_cnt = 0; tick_cnt = 0; hold_left = 0; held = 0; seen = 0; d0 = '0;
        exp_busy = exp_p * (td_of(u) + 2 * n) + ((hold_at >= 0) ? 3 : 0);
        first_idx = f; last_idx = l; target = tgt;
        start[u] = 1'b1;
        tick = (spacing == 0);
        @(negedge clk);
        start[u] = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            if (busy_s[u]) busy_cnt++;
            if (done_s[u]) seen = 1;
            else begin
                if (spacing > 0) begin
                    tick = ((cyc + 1) % spacing == 0);
                    if (tick) tick_cnt++;
                end
                if (bogus && exp_busy > 4 && cyc == 2) begin
                    start[u] = 1'b1;
                    first_idx = 6'($urandom); last_idx = 6'($urandom); target = 12'($urandom);
                end else begin
                    start[u] = 1'b0;
                end
                if (hold_left > 0) begin
                    chk({tag, " wren while hold"}, 32'(wren_s[u]), 32'd0);
                    hold_left--;
                    if (hold_left == 0) begin
                        hold = 1'b0;
                        #1;
                        chk({tag, " replay after hold"}, 32'({wren_s[u], addr_s[u], wdata_s[u]}),
                            32'({1'b1, 6'(hold_at), d0}));
                    end
                end else if (hold_at >= 0 && !held && wren_s[u] && addr_s[u] == 6'(hold_at)) begin
                    d0 = wdata_s[u]; held = 1; hold = 1'b1; hold_left = 3;
                    #1;
                    chk({tag, " hold gates wren"}, 32'(wren_s[u]), 32'd0);
                end
            end
            @(negedge clk);
        end
        tick = 1'b0; start[u] = 1'b0; hold = 1'b0;
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        if (spacing == 0) chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        else              chk({tag, " ticks consumed"}, 32'(tick_cnt), 32'(exp_p * td_of(u)));
        chk({tag, " idle after done"}, 32'({busy_s[u], done_s[u]}), 32'd0);
        chk({tag, " done pulses"}, 32'(done_n[u] - dbase), 32'd1);
        chk({tag, " write count"}, 32'(log_n(u) - base), 32'(exp_w.size()));
        mism = 0;
        for (int i = 0; i < exp_w.size() && base + i < log_n(u); i++)
            if (log_at(u, base + i) !== exp_w[i]) mism++;
        chk({tag, " write sequence"}, 32'(mism), 32'd0);
        chk_mem(u, tag);
`ifdef PALETTE_FADER_IRQ_EN
        chk({tag, " irq set"}, 32'(irq_s[u]), 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk({tag, " irq cleared"}, 32'(irq_s[u]), 32'd0);
`else
        chk({tag, " irq tied low"}, 32'(irq_s[u]), 32'd0);
`endif
        chk({tag, " upper wrdata bits"}, 32'(hi_bad), 32'd0);
        chk({tag, " writes under hold"}, 32'(hold_bad), 32'd0);
    endtask

    initial begin : main
        int base, dbase, b;
        bit found;
        logic [5:0] f, l;
        logic [17:0] w41[4];

        reset_n = 1'b0; abort = 1'b0; tick = 1'b0; hold = 1'b0; irq_clr = 1'b0;
        start = 2'b00; first_idx = '0; last_idx = '0; target = '0;
        load_req[0] = 1'b0; load_req[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset pal_addr", 32'(addr_s[u]), 32'd0);
            chk("reset pal_wrdata", 32'(wdata_s[u]), 32'd0);
            chk("reset outputs", 32'({wren_s[u], busy_s[u], done_s[u], irq_s[u]}), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", 32'({busy_s[0], busy_s[1], wren_s[0], wren_s[1]}), 32'd0);

        // Single entry fading to black, one tick every 200 cycles.
        rand_img();
        img0[5] = 12'h0F8;
        b = log_n(0);
        run_fade(0, 6'd5, 6'd5, 12'h000, 200, -1, 0, "fade 0F8");
        chk("fade 0F8 write passes", 32'(log_n(0) - b), 32'd15);
        chk("fade 0F8 last write", 32'(log_at(0, log_n(0) - 1)), 32'({6'd5, 12'h000}));

        // Wrapping range 62..1 with STEP=2.
        for (int i = 0; i < 64; i++) img0[i] = 12'h111;
        b = log_n(1);
        run_fade(1, 6'd62, 6'd1, 12'h333, 0, -1, 0, "wrap 62..1");
        w41[0] = {6'd62, 12'h333}; w41[1] = {6'd63, 12'h333};
        w41[2] = {6'd0, 12'h333};  w41[3] = {6'd1, 12'h333};
        for (int i = 0; i < 4; i++) chk("wrap pass-1 write", 32'(log_at(1, b + i)), 32'(w41[i]));

        // Range already at target: no writes, done after one pass.
        rand_img();
        for (int i = 30; i <= 35; i++) img0[i] = 12'h5A3;
        b = log_n(0);
        run_fade(0, 6'd30, 6'd35, 12'h5A3, 0, -1, 0, "at target");
        chk("at target no writes", 32'(log_n(0) - b), 32'd0);

        // Hold for three cycles on the write of entry 10.
        rand_img();
        img0[10] = 12'h000;
        run_fade(0, 6'd8, 6'd12, 12'hFFF, 0, 10, 0, "hold entry 10");

        // Abort during RD of the second pass.
        rand_img();
        for (int i = 20; i <= 22; i++) img0[i] = 12'h000;
        model(STEP_B, 6'd20, 6'd22, 12'hFFF, 1);
        load_mem(1);
        base = log_n(1); dbase = done_n[1];
        first_idx = 6'd20; last_idx = 6'd22; target = 12'hFFF;
        start[1] = 1'b1; tick = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            if (log_n(1) - base >= 3 && addr_s[1] == 6'd20 && !wren_s[1] && busy_s[1]) found = 1;
            else @(negedge clk);
        end
        chk("abort reached pass-2 RD", 32'(found), 32'd1);
        abort = 1'b1;
        #1;
        chk("abort cycle wren", 32'(wren_s[1]), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy_s[1]), 32'd0);
        chk("abort pal_addr", 32'(addr_s[1]), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort stays idle", 32'(busy_s[1]), 32'd0);
        tick = 1'b0;
        chk("abort no done", 32'(done_n[1] - dbase), 32'd0);
        chk("abort pass-1 writes", 32'(log_n(1) - base), 32'd3);
        chk_mem(1, "abort");

        // Abort while a write is being driven.
        rand_img();
        img0[5] = 12'h000;
        load_mem(0);
        base = log_n(0); dbase = done_n[0];
        first_idx = 6'd5; last_idx = 6'd5; target = 12'hFFF;
        start[0] = 1'b1; tick = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            if (wren_s[0]) found = 1;
            else @(negedge clk);
        end
        chk("abort-in-WR reached", 32'(found), 32'd1);
        abort = 1'b1;
        #1;
        chk("abort-in-WR wren", 32'(wren_s[0]), 32'd0);
        @(negedge clk);
        abort = 1'b0; tick = 1'b0;
        chk("abort-in-WR busy", 32'(busy_s[0]), 32'd0);
        chk("abort-in-WR no write", 32'(log_n(0) - base), 32'd0);
        chk("abort-in-WR entry kept", 32'(mem[0][5]), 32'h000);
        chk("abort-in-WR no done", 32'(done_n[0] - dbase), 32'd0);

        // Start and abort together in IDLE: abort wins.
        start[0] = 1'b1; abort = 1'b1; tick = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; abort = 1'b0;
        chk("start+abort idle", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        tick = 1'b0;
        chk("start+abort stays idle", 32'(busy_s[0]), 32'd0);

        // Reset while a write is being driven, then a normal fade.
        rand_img();
        img0[40] = 12'hFFF;
        load_mem(1);
        base = log_n(1);
        first_idx = 6'd40; last_idx = 6'd40; target = 12'h000;
        start[1] = 1'b1; tick = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            if (wren_s[1]) found = 1;
            else @(negedge clk);
        end
        chk("reset-in-WR reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset-in-WR wren", 32'(wren_s[1]), 32'd0);
        @(negedge clk);
        chk("reset-in-WR after edge", 32'({busy_s[1], wren_s[1], addr_s[1]}), 32'd0);
        chk("reset-in-WR no write", 32'(log_n(1) - base), 32'd0);
        reset_n = 1'b1; tick = 1'b0;
        @(negedge clk);
        rand_img();
        run_fade(1, 6'd40, 6'd44, 12'($urandom), 0, -1, 0, "after reset");

        // Random fades on both instances, with an ignored start mid-fade.
        for (int r = 0; r < 10; r++) begin
            int u;
            u = r % 2;
            rand_img();
            f = 6'($urandom_range(0, 63));
            l = 6'((int'(f) + $urandom_range(0, 9)) % 64);
            run_fade(u, f, l, 12'($urandom), 0, -1, 1, (u == 0) ? "random A" : "random B");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_fader.md
PALETTE_FADER -- requirements
Module: palette_fader

Interface
REQ-001 SHALL have parameter STEP, default 1, per-channel 4-bit increment applied per pass (1..15).
REQ-002 SHALL have parameter TICK_DIV, default 1, number of tick pulses consumed per pass (1..255).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; latches first_idx, last_idx and target, and begins a fade.
REQ-006 abort  input  1  stops the fade; has priority over start.
REQ-007 tick  input  1  frame-rate pulse (e.g. vblank); paces passes.
REQ-008 hold  input  1  palette host port is in use by the CPU; engine stalls.
REQ-009 first_idx  input  6  first palette entry of the range.
REQ-010 last_idx  input  6  last palette entry of the range, inclusive.
REQ-011 target  input  12  target colour {r[11:8], g[7:4], b[3:0]}.
REQ-012 pal_addr  output  6  palette host-port address.
REQ-013 pal_rddata  input  16  palette host-port read data; bits 11:0 used.
REQ-014 pal_wrdata  output  16  palette host-port write data; bits 15:12 always 0.
REQ-015 pal_wren  output  1  palette host-port write enable.
REQ-016 busy  output  1  high from the cycle after start until return to IDLE.
REQ-017 done  output  1  one-cycle pulse when the range has reached target.
REQ-018 irq  output  1  sticky done interrupt (see Configuration).
REQ-019 irq_clr  input  1  clears irq.

Function
REQ-020 States: IDLE, WAIT, RD, WR, DONE.
REQ-021 IDLE + start -> WAIT; the 6-bit index is loaded with first_idx, and the changed flag and tick counter are cleared.
REQ-022 WAIT: counts tick pulses; on the TICK_DIV-th pulse -> RD with index = first_idx and changed = 0.
REQ-023 RD: pal_addr = index and pal_wren = 0; pal_rddata is sampled at the end of this cycle (one-cycle read latency budget) -> WR.
REQ-024 WR: per channel, new = cur + min(STEP, tgt - cur) if cur < tgt; new = cur - min(STEP, cur - tgt) if cur > tgt; otherwise new = cur. Computation has no 4-bit overflow or underflow.
REQ-025 WR: if new != cur, pal_wren = 1 with pal_addr = index and pal_wrdata = {4'h0, new}, and changed is set; if new == cur, no write is issued.
REQ-026 WR: if index == last_idx, pass ends and state -> DONE if changed == 0 after this entry, else -> WAIT; otherwise index += 1 (mod 64) and state -> RD.
REQ-027 Range wraps: if first_idx > last_idx, the pass covers first_idx..63, then 0..last_idx; if first_idx == last_idx, the pass covers exactly one entry.
REQ-028 DONE: done = 1 for one cycle -> IDLE; busy drops in the same cycle.
REQ-029 Ticks arriving during RD or WR are ignored and not counted.
REQ-030 hold = 1 in RD or WR: pal_wren forced 0, state and index frozen; the same cycle is replayed when hold falls.
REQ-031 start while busy is ignored; range and target are not re-latched mid-fade.
REQ-032 abort in any non-IDLE state -> IDLE next cycle, pal_wren = 0 that cycle, no done pulse; already written entries keep their values.
REQ-033 Outside WR, pal_wren = 0; pal_addr = index in RD and WR, and 0 elsewhere.
REQ-034 Worst-case pass length without hold = 128 cycles (64 entries x 2 cycles).

Reset
REQ-035 reset_n = 0 at a clock edge -> state IDLE, index 0, tick counter 0, changed 0.
REQ-036 During and after reset, until the next start, outputs are: pal_addr = 0, pal_wrdata = 0, pal_wren = 0, busy = 0, done = 0, irq = 0.
REQ-037 Reset mid-pass aborts with no further write; the entry being written in that cycle is not written.

Configuration
REQ-038 Macro PALETTE_FADER_IRQ_EN defined: irq is set on the done cycle, held until irq_clr; if irq_clr and done coincide, set wins.
REQ-039 Macro PALETTE_FADER_IRQ_EN undefined: irq is tied 0 and irq_clr is ignored; all other behaviour is identical.

Verification
REQ-040 Entry 5 = 12'h0F8, range 5..5, target 12'h000, STEP=1, TICK_DIV=1, tick every 200 cycles -> 15 passes with writes (last written value 12'h000), then one write-free pass, then a done pulse.
REQ-041 Range 62..1, all entries 12'h111, target 12'h333, STEP=2 -> writes at addr 62, 63, 0, 1 with 12'h333 in pass 1; done after pass 2.
REQ-042 hold asserted for 3 cycles during WR of entry 10 -> no pal_wren while hold = 1; exactly one write to entry 10 after release, with the same data.
REQ-043 abort during RD of pass 2 -> IDLE next cycle, busy = 0, no done pulse, pass-1 values remain in the palette.
REQ-044 Range already equal to target -> no pal_wren at all, done pulse after the first pass; with PALETTE_FADER_IRQ_EN, irq = 1 until irq_clr.
REQ-045 reset_n low during WR with pal_wren high -> pal_wren = 0 and busy = 0 at the following edge; a start pulse after reset runs normally.
